// File: rtl/subpix_pkg.sv
// Shared constants, tap sets, phase codes and FSM states for the 8x8 HEVC luma sub-pixel interpolator.
package subpix_pkg;
  localparam int PIX_W = 8;
  localparam int BLK   = 8;
  localparam int WIN   = 15;
  localparam int NBLK  = 5;

  localparam logic [1:0] PH_A = 2'd0;
  localparam logic [1:0] PH_B = 2'd1;
  localparam logic [1:0] PH_C = 2'd2;

  localparam int TAPS_A [8] = '{-1, 4, -10, 58, 17, -5, 1, 0};
  localparam int TAPS_B [8] = '{-1, 4, -11, 40, 40, -11, 4, -1};
  localparam int TAPS_C [8] = '{0, 1, -5, 17, 58, -10, 4, -1};

  typedef enum logic [1:0] {LOAD = 2'd0, VERT = 2'd1, DONE = 2'd2} state_t;

  typedef logic [BLK-1:0][PIX_W-1:0] row_t;
endpackage

// File: rtl/fir8_mless.sv
// 8-tap multiplierless HEVC luma filter (phase A/B/C); rounding offset enabled by SUBPIX_ROUND_EN.
module fir8_mless
  import subpix_pkg::*;
(
  input  row_t             pix,
  input  logic [1:0]       phase,
  output logic [PIX_W-1:0] y
);
  logic signed [15:0] p [8];
  logic signed [15:0] acc;

  function automatic logic [PIX_W-1:0] round_clip(input logic signed [15:0] s);
    logic signed [15:0] t;
`ifdef SUBPIX_ROUND_EN
    t = (s + 16'sd32) >>> 6;
`else
    t = s >>> 6;
`endif
    if (t < 16'sd0) return '0;
    else if (t > 16'sd255) return 8'd255;
    else return t[7:0];
  endfunction

  for (genvar k = 0; k < 8; k++) begin : g_ext
    assign p[k] = $signed({8'd0, pix[k]});
  end

  // Coefficients decomposed: 58=64-4-2, 17=16+1, 10=8+2, 11=8+2+1, 40=32+8, 5=4+1
  always_comb begin
    case (phase)
      PH_A: acc = -p[0] + (p[1] <<< 2) - ((p[2] <<< 3) + (p[2] <<< 1))
                  + ((p[3] <<< 6) - (p[3] <<< 2) - (p[3] <<< 1))
                  + ((p[4] <<< 4) + p[4]) - ((p[5] <<< 2) + p[5]) + p[6];
      PH_B: acc = -p[0] + (p[1] <<< 2) - ((p[2] <<< 3) + (p[2] <<< 1) + p[2])
                  + ((p[3] <<< 5) + (p[3] <<< 3)) + ((p[4] <<< 5) + (p[4] <<< 3))
                  - ((p[5] <<< 3) + (p[5] <<< 1) + p[5]) + (p[6] <<< 2) - p[7];
      PH_C: acc = p[1] - ((p[2] <<< 2) + p[2]) + ((p[3] <<< 4) + p[3])
                  + ((p[4] <<< 6) - (p[4] <<< 2) - (p[4] <<< 1))
                  - ((p[5] <<< 3) + (p[5] <<< 1)) + (p[6] <<< 2) - p[7];
      default: acc = '0;
    endcase
  end

  assign y = round_clip(acc);
endmodule

// File: rtl/subpixel_interpolation_8x8.sv
// Two-pass (horizontal then vertical) 8x8 luma fractional-sample interpolator over a 15x15 window.
// Build option SUBPIX_ROUND_EN (in fir8_mless) selects round-to-nearest instead of floor.
module subpixel_interpolation_8x8
  import subpix_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIN*PIX_W-1:0]   in_row,
  output logic [63:0]            next_row,
  output logic [2559:0]          out_A,
  output logic [2559:0]          out_B,
  output logic [2559:0]          out_C,
  output logic [63:0]            fir_out_a,
  output logic [63:0]            fir_out_b,
  output logic [63:0]            fir_out_c,
  output logic [959:0]           temp_A,
  output logic [959:0]           temp_B,
  output logic [959:0]           temp_C,
  output logic [7:0]             cnt,
  output logic [7:0]             sel,
  output logic                   load_out,
  output logic [WIN*PIX_W-1:0]   currentPixels
);
  state_t                      state_q, state_d;
  logic [7:0]                  cnt_q, cnt_d, sel_q, sel_d;
  logic                        load_q, load_d;
  logic [WIN*PIX_W-1:0]        cur_q, cur_d;
  row_t [WIN-1:0]              store_q, store_d;
  row_t [2:0][WIN-1:0]         temp_q, temp_d;
  row_t [2:0][NBLK*BLK-1:0]    bank_q, bank_d;
  row_t [2:0]                  fir_q, fir_d;
  row_t [2:0][BLK-1:0]         taps;
  row_t [2:0]                  fir_res;
  logic [1:0]                  src_sel;
  logic [5:0]                  blk_row;

  assign src_sel = (sel_q[1:0] == 2'd0) ? 2'd0 : sel_q[1:0] - 2'd1;
  assign blk_row = {sel_q[2:0] + 3'd1, cnt_q[2:0]};

  // Filter bank is shared: row pixels in LOAD, a column slice of the selected source in VERT
  for (genvar x = 0; x < 3; x++) begin : g_ph
    for (genvar c = 0; c < BLK; c++) begin : g_col
      for (genvar k = 0; k < 8; k++) begin : g_tap
        localparam logic [3:0] K = 4'(k);
        assign taps[x][c][k] = (state_q == LOAD) ? in_row[PIX_W*(c+k) +: PIX_W] :
                               (sel_q == 8'd0)   ? store_q[cnt_q[3:0] + K][c] :
                                                   temp_q[src_sel][cnt_q[3:0] + K][c];
      end
      fir8_mless u_fir (
        .pix   (taps[x][c]),
        .phase (2'(x)),
        .y     (fir_res[x][c])
      );
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    load_d  = load_q;
    cur_d   = cur_q;
    store_d = store_q;
    temp_d  = temp_q;
    bank_d  = bank_q;
    fir_d   = fir_q;
    case (state_q)
      LOAD: begin
        cur_d = in_row;
        store_d[cnt_q[3:0]] = in_row[3*PIX_W +: BLK*PIX_W];
        for (int x = 0; x < 3; x++) begin
          temp_d[x][cnt_q[3:0]] = fir_res[x];
          fir_d[x] = fir_res[x];
          if (cnt_q >= 8'd3 && cnt_q <= 8'd10) bank_d[x][cnt_q[5:0] - 6'd3] = fir_res[x];
        end
        if (cnt_q == 8'd14) begin
          cnt_d   = '0;
          sel_d   = '0;
          state_d = VERT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      VERT: begin
        for (int x = 0; x < 3; x++) begin
          bank_d[x][blk_row] = fir_res[x];
          fir_d[x] = fir_res[x];
        end
        if (cnt_q == 8'd7) begin
          cnt_d = '0;
          if (sel_q == 8'd3) begin
            state_d = DONE;
            load_d  = 1'b1;
          end else begin
            sel_d = sel_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      sel_q   <= '0;
      load_q  <= 1'b0;
      cur_q   <= '0;
      store_q <= '0;
      temp_q  <= '0;
      bank_q  <= '0;
      fir_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      load_q  <= load_d;
      cur_q   <= cur_d;
      store_q <= store_d;
      temp_q  <= temp_d;
      bank_q  <= bank_d;
      fir_q   <= fir_d;
    end
  end

  assign next_row      = (state_q == LOAD) ? {56'd0, cnt_q} : 64'd0;
  assign out_A         = bank_q[0];
  assign out_B         = bank_q[1];
  assign out_C         = bank_q[2];
  assign temp_A        = temp_q[0];
  assign temp_B        = temp_q[1];
  assign temp_C        = temp_q[2];
  assign fir_out_a     = fir_q[0];
  assign fir_out_b     = fir_q[1];
  assign fir_out_c     = fir_q[2];
  assign cnt           = cnt_q;
  assign sel           = sel_q;
  assign load_out      = load_q;
  assign currentPixels = cur_q;
endmodule

// File: tb/tb_subpixel_interpolation_8x8.sv
// Scoreboard bench: a window-level reference model predicts all banks; a monitor checks them when load_out rises.
`timescale 1ns/1ps
module tb_subpixel_interpolation_8x8;
  typedef struct {
    logic [2:0][2559:0] bank;
    logic [2:0][959:0]  temp;
    logic [2:0][63:0]   fo;
    logic [119:0]       cur;
  } exp_t;

  localparam int TAPS [3][8] = '{'{-1, 4, -10, 58, 17, -5, 1, 0},
                                 '{-1, 4, -11, 40, 40, -11, 4, -1},
                                 '{0, 1, -5, 17, 58, -10, 4, -1}};

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [119:0]  in_row;
  logic [63:0]   next_row;
  logic [2559:0] out_A, out_B, out_C;
  logic [63:0]   fir_out_a, fir_out_b, fir_out_c;
  logic [959:0]  temp_A, temp_B, temp_C;
  logic [7:0]    cnt, sel;
  logic          load_out;
  logic [119:0]  currentPixels;

  int   total = 0;
  int   bad   = 0;
  exp_t sb[$];
  logic [7:0] win [15][15];

  subpixel_interpolation_8x8 dut (
    .clk(clk), .rst(rst), .in_row(in_row), .next_row(next_row),
    .out_A(out_A), .out_B(out_B), .out_C(out_C),
    .fir_out_a(fir_out_a), .fir_out_b(fir_out_b), .fir_out_c(fir_out_c),
    .temp_A(temp_A), .temp_B(temp_B), .temp_C(temp_C),
    .cnt(cnt), .sel(sel), .load_out(load_out), .currentPixels(currentPixels)
  );

  always #5 clk = ~clk;

  // Row fetcher: answers next_row combinationally
  always @* begin
    in_row = '0;
    if (next_row < 64'd15)
      for (int i = 0; i < 15; i++) in_row[8*i +: 8] = win[next_row[3:0]][i];
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  function automatic int filt(int ph, int p[8]);
    int s = 0;
    for (int k = 0; k < 8; k++) s += TAPS[ph][k] * p[k];
`ifdef SUBPIX_ROUND_EN
    s += 32;
`endif
    s = s >>> 6;
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  task automatic build_exp(output exp_t e);
    int src [4][15][8];
    int p [8];
    int v;
    e.bank = '0; e.temp = '0; e.fo = '0; e.cur = '0;
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 8; c++) src[0][r][c] = int'(win[r][c+3]);
    for (int x = 0; x < 3; x++)
      for (int r = 0; r < 15; r++)
        for (int c = 0; c < 8; c++) begin
          for (int k = 0; k < 8; k++) p[k] = int'(win[r][c+k]);
          v = filt(x, p);
          src[x+1][r][c] = v;
          e.temp[x][r*64 + c*8 +: 8] = 8'(v);
          if (r >= 3 && r <= 10) e.bank[x][(r-3)*64 + c*8 +: 8] = 8'(v);
        end
    for (int s = 0; s < 4; s++)
      for (int x = 0; x < 3; x++)
        for (int r = 0; r < 8; r++)
          for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < 8; k++) p[k] = src[s][r+k][c];
            e.bank[x][((s+1)*8 + r)*64 + c*8 +: 8] = 8'(filt(x, p));
          end
    for (int x = 0; x < 3; x++) e.fo[x] = e.bank[x][39*64 +: 64];
    for (int i = 0; i < 15; i++) e.cur[8*i +: 8] = win[14][i];
  endtask

  function automatic logic [2559:0] dut_bank(int x);
    return (x == 0) ? out_A : ((x == 1) ? out_B : out_C);
  endfunction
  function automatic logic [959:0] dut_temp(int x);
    return (x == 0) ? temp_A : ((x == 1) ? temp_B : temp_C);
  endfunction
  function automatic logic [63:0] dut_fo(int x);
    return (x == 0) ? fir_out_a : ((x == 1) ? fir_out_b : fir_out_c);
  endfunction

  // Monitor: a rising load_out presents a finished block
  initial begin : monitor
    exp_t e;
    logic prev_load;
    prev_load = 1'b0;
    forever begin
      @(negedge clk);
      if (load_out === 1'b1 && prev_load !== 1'b1) begin
        if (sb.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_done got=1 want=no_pending_block");
        end else begin
          e = sb.pop_front();
          for (int x = 0; x < 3; x++) begin
            for (int r = 0; r < 40; r++)
              chk($sformatf("bank%0d_blk%0d_row%0d", x, r/8, r%8),
                  128'(dut_bank(x)[r*64 +: 64]), 128'(e.bank[x][r*64 +: 64]));
            for (int r = 0; r < 15; r++)
              chk($sformatf("temp%0d_row%0d", x, r),
                  128'(dut_temp(x)[r*64 +: 64]), 128'(e.temp[x][r*64 +: 64]));
            chk($sformatf("fir_out%0d", x), 128'(dut_fo(x)), 128'(e.fo[x]));
          end
          chk("currentPixels", 128'(currentPixels), 128'(e.cur));
        end
      end
      prev_load = load_out;
    end
  end

  task automatic run_window(input string tag);
    exp_t e;
    build_exp(e);
    sb.push_back(e);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_rst_load_out"}, 128'(load_out), 128'(0));
    chk({tag, "_rst_cnt"}, 128'(cnt), 128'(0));
    chk({tag, "_rst_outA_any"}, 128'(|out_A), 128'(0));
    rst = 1'b0;
    for (int i = 0; i < 15; i++) begin
      chk($sformatf("%s_load_next_row%0d", tag, i), 128'(next_row), 128'(i));
      chk($sformatf("%s_load_cnt%0d", tag, i), 128'(cnt), 128'(i));
      @(negedge clk);
    end
    for (int j = 0; j < 32; j++) begin
      chk($sformatf("%s_vert_sel%0d", tag, j), 128'(sel), 128'(j/8));
      chk($sformatf("%s_vert_cnt%0d", tag, j), 128'(cnt), 128'(j%8));
      chk($sformatf("%s_vert_next_row%0d", tag, j), 128'(next_row), 128'(0));
      chk($sformatf("%s_vert_load_out%0d", tag, j), 128'(load_out), 128'(0));
      @(negedge clk);
    end
    chk({tag, "_load_out_edge47"}, 128'(load_out), 128'(1));
    repeat (3) @(negedge clk);
    chk({tag, "_done_hold_load_out"}, 128'(load_out), 128'(1));
    chk({tag, "_done_hold_fir_a"}, 128'(fir_out_a), 128'(e.fo[0]));
  endtask

  task automatic fill_random(input bit extremes);
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 15; c++)
        win[r][c] = extremes ? (($urandom_range(0, 1) == 1) ? 8'd255 : 8'd0) : 8'($urandom_range(0, 255));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    // Uniform window
    for (int r = 0; r < 15; r++) for (int c = 0; c < 15; c++) win[r][c] = 8'd100;
    run_window("uniform");
    chk("uniform_outA_row0", 128'(out_A[63:0]), 128'(64'h6464646464646464));

    // Impulse at (7,7)
    for (int r = 0; r < 15; r++) for (int c = 0; c < 15; c++) win[r][c] = 8'd0;
    win[7][7] = 8'd64;
    run_window("impulse");
    chk("impulse_outA_blk0_row4", 128'(out_A[4*64 +: 64]),
        128'({8'd0, 8'd4, 8'd0, 8'd58, 8'd17, 8'd0, 8'd1, 8'd0}));
    chk("impulse_outA_blk0_row3", 128'(out_A[3*64 +: 64]), 128'(0));

    // Row-constant image
    for (int r = 0; r < 15; r++) for (int c = 0; c < 15; c++) win[r][c] = 8'(10*r);
    run_window("rowconst");
    chk("rowconst_outB_blk1_row0", 128'(out_B[8*64 +: 64]), 128'(64'h2323232323232323));

    // Random and clipping-heavy windows
    for (int t = 0; t < 4; t++) begin
      fill_random(1'b0);
      run_window($sformatf("rand%0d", t));
    end
    fill_random(1'b1);
    run_window("extreme");

    // Abort mid-run with reset, then a full rerun of the same window
    fill_random(1'b0);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_outA_any", 128'(|out_A), 128'(0));
    chk("midrst_outB_any", 128'(|out_B), 128'(0));
    chk("midrst_tempC_any", 128'(|temp_C), 128'(0));
    chk("midrst_fir_b", 128'(fir_out_b), 128'(0));
    chk("midrst_cnt", 128'(cnt), 128'(0));
    chk("midrst_sel", 128'(sel), 128'(0));
    chk("midrst_cur", 128'(currentPixels), 128'(0));
    chk("midrst_next_row", 128'(next_row), 128'(0));
    run_window("after_rst");

    repeat (5) @(negedge clk);
    chk("scoreboard_empty", 128'(sb.size()), 128'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
